// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - time-multiplexed seven-segment scanner for packed BCD counts
module bcd_display_scanner #(
  parameter int NUM_DIGITS         = 2,
  parameter int REFRESH_DIV        = 100_000,
  parameter int BLANK_CYCLES       = 1_000,
  parameter int LEADING_ZERO_BLANK = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] number,
  input  logic                    enable,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t                  state, state_n;
  logic [IW-1:0]           idx, idx_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_n;

  logic [3:0]              cur_nib;
  logic [NUM_DIGITS-1:0]   upper_zero;
  logic                    lz_blank;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  // State, slot counter, digit index and frame shadow registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      shadow <= '0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      cnt    <= cnt_n;
      shadow <= shadow_n;
    end
  end

  // Next-state: slot timing, digit advance and once-per-frame shadow reload
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    cnt_n    = cnt;
    shadow_n = shadow;
    case (state)
      IDLE: begin
        if (enable) begin
          shadow_n = number;
          idx_n    = '0;
          cnt_n    = '0;
          state_n  = BLANK;
        end
      end
      BLANK: begin
        if (!enable) begin
          idx_n   = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt == BLANK_LAST) begin
          cnt_n   = '0;
          state_n = SHOW;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SHOW: begin
        if (!enable) begin
          idx_n   = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt == SHOW_LAST) begin
          cnt_n   = '0;
          state_n = BLANK;
          if (idx == IDX_LAST) begin
            idx_n    = '0;
            shadow_n = number;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        idx_n   = '0;
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Per-digit flag: this nibble and every more significant nibble are zero
  always_comb begin
    logic run;
    run        = 1'b1;
    upper_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run           = run & (shadow[4*i +: 4] == 4'd0);
      upper_zero[i] = run;
    end
  end

  // Outputs decoded purely from registered state and shadow
  always_comb begin
    cur_nib    = shadow[{idx, 2'b00} +: 4];
    lz_blank   = (LEADING_ZERO_BLANK != 0) && (idx != '0) && upper_zero[idx];
    seg        = '0;
    digit_sel  = '0;
    frame_done = 1'b0;
    if (state != IDLE && !lz_blank) begin
      seg = decode(cur_nib);
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_sel[i] = (state == SHOW) && (idx == IW'(i));
    end
    frame_done = (state == SHOW) && (idx == IDX_LAST) && (cnt == SHOW_LAST);
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - self-checking bench for bcd_display_scanner
module tb_bcd_display_scanner;

  localparam int ND  = 2;
  localparam int RD  = 8;
  localparam int BC  = 2;
  localparam int FRM = ND * RD;

  logic          clk;
  logic          rst;
  logic [7:0]    number;
  logic          enable;
  logic [6:0]    seg_lz, seg_nz;
  logic [1:0]    dsel_lz, dsel_nz;
  logic          fd_lz, fd_nz;

  int vectors;
  int miscompares;

  bcd_display_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LEADING_ZERO_BLANK(1)) dut_lz (
    .clk(clk), .rst(rst), .number(number), .enable(enable),
    .seg(seg_lz), .digit_sel(dsel_lz), .frame_done(fd_lz)
  );

  bcd_display_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LEADING_ZERO_BLANK(0)) dut_nz (
    .clk(clk), .rst(rst), .number(number), .enable(enable),
    .seg(seg_nz), .digit_sel(dsel_nz), .frame_done(fd_nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position within the frame plus the latched number
  bit         m_active;
  int         m_pos;
  logic [7:0] m_shadow;
  logic [6:0] seg_tab [16];

  task automatic model_update();
    if (rst) begin
      m_active = 0; m_pos = 0; m_shadow = '0;
    end else if (!m_active) begin
      if (enable) begin
        m_active = 1; m_pos = 0; m_shadow = number;
      end
    end else if (!enable) begin
      m_active = 0; m_pos = 0;
    end else if (m_pos == FRM - 1) begin
      m_pos = 0; m_shadow = number;
    end else begin
      m_pos++;
    end
  endtask

  task automatic model_out(input bit lzb, output logic [6:0] s, output logic [1:0] d, output logic f);
    int slot, off;
    logic [7:0] above;
    s = '0; d = '0; f = 1'b0;
    if (m_active) begin
      slot  = m_pos / RD;
      off   = m_pos % RD;
      above = m_shadow >> (4 * slot);
      if (!(lzb && slot > 0 && above == 0)) s = seg_tab[above[3:0]];
      if (off >= BC) d = 2'(1 << slot);
      f = (m_pos == FRM - 1);
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    logic [6:0] s; logic [1:0] d; logic f;
    model_out(1'b1, s, d, f);
    chk("lz_seg", 16'(seg_lz), 16'(s));
    chk("lz_dsel", 16'(dsel_lz), 16'(d));
    chk("lz_fd", 16'(fd_lz), 16'(f));
    model_out(1'b0, s, d, f);
    chk("nz_seg", 16'(seg_nz), 16'(s));
    chk("nz_dsel", 16'(dsel_nz), 16'(d));
    chk("nz_fd", 16'(fd_nz), 16'(f));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0] num;
    bit         lzb;
    logic [6:0] s0;
    logic [6:0] s1;
  } vec_t;

  vec_t tbl [8];

  initial begin
    vectors = 0; miscompares = 0;
    m_active = 0; m_pos = 0; m_shadow = '0;
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    tbl[0] = '{8'h10, 1'b1, 7'h3F, 7'h06};
    tbl[1] = '{8'h05, 1'b1, 7'h6D, 7'h00};
    tbl[2] = '{8'h00, 1'b1, 7'h3F, 7'h00};
    tbl[3] = '{8'h05, 1'b0, 7'h6D, 7'h3F};
    tbl[4] = '{8'h00, 1'b0, 7'h3F, 7'h3F};
    tbl[5] = '{8'hA9, 1'b1, 7'h6F, 7'h40};
    tbl[6] = '{8'h0A, 1'b1, 7'h40, 7'h00};
    tbl[7] = '{8'h59, 1'b0, 7'h6F, 7'h6D};

    // Reset held with enable high: outputs stay dark
    rst = 1'b1; enable = 1'b1; number = 8'h59;
    #1;
    chk("reset_seg", 16'(seg_lz), 16'h0);
    chk("reset_dsel", 16'(dsel_lz), 16'h0);
    chk("reset_fd", 16'(fd_lz), 16'h0);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b0;
    for (int i = 0; i < 2 * FRM; i++) step();

    // Directed per-frame vectors
    for (int v = 0; v < 8; v++) begin
      enable = 1'b0;
      do_reset();
      number = tbl[v].num;
      enable = 1'b1;
      for (int c = 1; c <= FRM; c++) begin
        step();
        if (c == 1) begin
          chk("tbl_blank_dsel", 16'(tbl[v].lzb ? dsel_lz : dsel_nz), 16'h0);
          chk("tbl_blank_seg", 16'(tbl[v].lzb ? seg_lz : seg_nz), 16'(tbl[v].s0));
        end
        if (c == BC + 1) begin
          chk("tbl_d0_seg", 16'(tbl[v].lzb ? seg_lz : seg_nz), 16'(tbl[v].s0));
          chk("tbl_d0_dsel", 16'(tbl[v].lzb ? dsel_lz : dsel_nz), 16'h1);
        end
        if (c == RD + BC + 1) begin
          chk("tbl_d1_seg", 16'(tbl[v].lzb ? seg_lz : seg_nz), 16'(tbl[v].s1));
          chk("tbl_d1_dsel", 16'(tbl[v].lzb ? dsel_lz : dsel_nz), 16'h2);
        end
        if (c == FRM - 1) chk("tbl_fd_early", 16'(fd_lz), 16'h0);
        if (c == FRM)     chk("tbl_fd_last", 16'(fd_lz), 16'h1);
      end
    end

    // Tear-free update: change number during digit 0 SHOW
    enable = 1'b0;
    do_reset();
    number = 8'h12; enable = 1'b1;
    for (int c = 1; c <= 4; c++) step();
    number = 8'h34;
    for (int c = 5; c <= RD + BC + 1; c++) step();
    chk("tear_d1_same_frame", 16'(seg_lz), 16'h06);
    for (int c = RD + BC + 2; c <= FRM + BC + 1; c++) step();
    chk("tear_next_d0", 16'(seg_lz), 16'h66);
    for (int c = FRM + BC + 2; c <= FRM + RD + BC + 1; c++) step();
    chk("tear_next_d1", 16'(seg_lz), 16'h4F);

    // Enable dropped mid-SHOW, then re-enabled with a fresh number
    enable = 1'b0;
    do_reset();
    number = 8'h27; enable = 1'b1;
    for (int c = 1; c <= 5; c++) step();
    enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("disable_seg", 16'(seg_lz), 16'h0);
      chk("disable_dsel", 16'(dsel_lz), 16'h0);
      chk("disable_fd", 16'(fd_lz), 16'h0);
    end
    number = 8'h83; enable = 1'b1;
    step();
    chk("reen_blank_seg", 16'(seg_lz), 16'h4F);
    chk("reen_blank_dsel", 16'(dsel_lz), 16'h0);
    step(); step();
    chk("reen_show_dsel", 16'(dsel_lz), 16'h1);

    // Asynchronous reset pulse in BLANK
    for (int c = 0; c < RD - 1; c++) step();
    rst = 1'b1;
    #1;
    m_active = 0; m_pos = 0; m_shadow = '0;
    chk("async_rst_seg", 16'(seg_lz), 16'h0);
    chk("async_rst_dsel", 16'(dsel_lz), 16'h0);
    check_model();
    step();
    rst = 1'b0;
    for (int c = 0; c < FRM; c++) step();

    // Randomized run against the reference model
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 12) begin
        number[3:0] = 4'($urandom_range(0, 15));
        number[7:4] = (r < 4) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      if (enable) enable = (r >= 3);
      else        enable = (r < 60);
      rst = (r == 199);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
